// File: rtl/handshake_const_checker.sv
// rtl/handshake_const_checker.sv - elastic sink that compares tokens against a constant
module handshake_const_checker #(
  parameter int                    DATA_WIDTH  = 37,
  parameter logic [DATA_WIDTH-1:0] CONST_VALUE = 37'h0A1623B882,
  parameter int                    CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic [CNT_WIDTH-1:0]  match_count,
  output logic [CNT_WIDTH-1:0]  mismatch_count,
  output logic                  err_sticky
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Each slot stores only the 1-bit compare result; the data itself is never kept.
  logic main_valid;
  logic main_data;
  logic skid_valid;
  logic skid_data;

  logic in_xfer;
  logic out_xfer;
  logic is_match;

  // ready comes straight from the skid flop, so it never looks at outs_ready
  assign ins_ready  = ~skid_valid;
  assign outs       = main_data;
  assign outs_valid = main_valid;

  assign is_match = (ins == CONST_VALUE);
  assign in_xfer  = ins_valid & ins_ready;
  assign out_xfer = main_valid & outs_ready;

  // Two-slot elastic buffer; the skid slot is only ever full while main is full
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= 1'b0;
      main_data  <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= 1'b0;
    end else if (!main_valid) begin
      if (in_xfer) begin
        main_valid <= 1'b1;
        main_data  <= is_match;
      end
    end else if (out_xfer) begin
      if (skid_valid) begin
        // input cannot be present here since ins_ready was low
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= in_xfer;
        if (in_xfer) begin
          main_data <= is_match;
        end
      end
    end else if (in_xfer) begin
      skid_valid <= 1'b1;
      skid_data  <= is_match;
    end
  end

  // Saturating statistics and sticky error, counted at acceptance time
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_count    <= '0;
      mismatch_count <= '0;
      err_sticky     <= 1'b0;
    end else if (in_xfer) begin
      if (is_match) begin
        if (match_count != CNT_MAX) begin
          match_count <= match_count + 1'b1;
        end
      end else begin
        if (mismatch_count != CNT_MAX) begin
          mismatch_count <= mismatch_count + 1'b1;
        end
        err_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_handshake_const_checker.sv
// tb/tb_handshake_const_checker.sv - directed and throttled checks of handshake_const_checker
module tb_handshake_const_checker;

  localparam logic [36:0] K = 37'h0A1623B882;

  logic        clk = 1'b0;
  logic        rst;
  logic [36:0] ins;
  logic        ins_valid;
  logic        outs_ready;

  logic        ins_ready, outs, outs_valid, err_sticky;
  logic [15:0] match_count, mismatch_count;

  logic        ins_ready4, outs4, outs_valid4, err_sticky4;
  logic [3:0]  match_count4, mismatch_count4;

  int tests_run = 0;
  int tests_failed = 0;

  logic        tok_exp [1000];
  logic [36:0] tok_dat [1000];

  always #5 clk = ~clk;

  handshake_const_checker dut (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .outs(outs), .outs_valid(outs_valid), .outs_ready(outs_ready),
    .match_count(match_count), .mismatch_count(mismatch_count), .err_sticky(err_sticky)
  );

  handshake_const_checker #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready4),
    .outs(outs4), .outs_valid(outs_valid4), .outs_ready(outs_ready),
    .match_count(match_count4), .mismatch_count(mismatch_count4), .err_sticky(err_sticky4)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    ins_valid = 1'b0;
    outs_ready = 1'b0;
    ins = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    tests_run++; if (outs_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_outs_valid got %b want 0", outs_valid); end
    tests_run++; if (outs !== 1'b0) begin tests_failed++; $display("FAIL reset_outs got %b want 0", outs); end
    tests_run++; if (ins_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ins_ready got %b want 1", ins_ready); end
    tests_run++; if (match_count !== 16'd0) begin tests_failed++; $display("FAIL reset_match_count got %0d want 0", match_count); end
    tests_run++; if (mismatch_count !== 16'd0) begin tests_failed++; $display("FAIL reset_mismatch_count got %0d want 0", mismatch_count); end
    tests_run++; if (err_sticky !== 1'b0) begin tests_failed++; $display("FAIL reset_err_sticky got %b want 0", err_sticky); end
  endtask

  task automatic test_single;
    do_reset();
    outs_ready = 1'b1;
    ins = K;
    ins_valid = 1'b1;
    step();
    ins_valid = 1'b0;
    tests_run++; if (outs_valid !== 1'b1) begin tests_failed++; $display("FAIL single_outs_valid got %b want 1", outs_valid); end
    tests_run++; if (outs !== 1'b1) begin tests_failed++; $display("FAIL single_outs got %b want 1", outs); end
    tests_run++; if (match_count !== 16'd1) begin tests_failed++; $display("FAIL single_match_count got %0d want 1", match_count); end
    tests_run++; if (mismatch_count !== 16'd0) begin tests_failed++; $display("FAIL single_mismatch_count got %0d want 0", mismatch_count); end
    tests_run++; if (err_sticky !== 1'b0) begin tests_failed++; $display("FAIL single_err_sticky got %b want 0", err_sticky); end
  endtask

  task automatic test_back_to_back;
    int got, bad, drop, first_c, last_c;
    got = 0; bad = 0; drop = 0; first_c = -1; last_c = -1;
    do_reset();
    outs_ready = 1'b1;
    ins = K;
    for (int c = 0; c < 12; c++) begin
      ins_valid = (c < 8);
      if (ins_valid && !ins_ready) drop++;
      if (outs_valid && outs_ready) begin
        got++;
        if (outs !== 1'b1) bad++;
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      step();
    end
    ins_valid = 1'b0;
    tests_run++; if (got != 8) begin tests_failed++; $display("FAIL b2b_result_count got %0d want 8", got); end
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL b2b_result_value got %0d zeros want 0", bad); end
    tests_run++; if (drop != 0) begin tests_failed++; $display("FAIL b2b_ins_ready_drops got %0d want 0", drop); end
    tests_run++; if (first_c != 1 || last_c != 8) begin tests_failed++; $display("FAIL b2b_timing got first %0d last %0d want 1 8", first_c, last_c); end
    tests_run++; if (match_count !== 16'd8) begin tests_failed++; $display("FAIL b2b_match_count got %0d want 8", match_count); end
  endtask

  task automatic test_backpressure;
    int n;
    logic [2:0] seq;
    logic fire_in;
    n = 0; seq = '0;
    do_reset();
    outs_ready = 1'b0;
    ins = K; ins_valid = 1'b1;
    step();
    ins = K ^ 37'd1;
    step();
    tests_run++; if (ins_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_drop got %b want 0", ins_ready); end
    ins = K;
    step();
    tests_run++; if (ins_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_held got %b want 0", ins_ready); end
    tests_run++; if (mismatch_count !== 16'd1) begin tests_failed++; $display("FAIL bp_mismatch_count got %0d want 1", mismatch_count); end
    tests_run++; if (match_count !== 16'd1) begin tests_failed++; $display("FAIL bp_match_count_stalled got %0d want 1", match_count); end
    tests_run++; if (err_sticky !== 1'b1) begin tests_failed++; $display("FAIL bp_err_sticky got %b want 1", err_sticky); end
    outs_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      fire_in = ins_valid && ins_ready;
      if (outs_valid && outs_ready) begin
        if (n < 3) seq[n] = outs;
        n++;
      end
      step();
      if (fire_in) ins_valid = 1'b0;
    end
    tests_run++; if (n != 3) begin tests_failed++; $display("FAIL bp_result_count got %0d want 3", n); end
    tests_run++; if (seq !== 3'b101) begin tests_failed++; $display("FAIL bp_sequence got %b want 101 (1,0,1)", seq); end
    ins = K; ins_valid = 1'b1;
    step(); step();
    ins_valid = 1'b0;
    step();
    tests_run++; if (err_sticky !== 1'b1) begin tests_failed++; $display("FAIL bp_err_stays got %b want 1", err_sticky); end
    tests_run++; if (match_count !== 16'd4) begin tests_failed++; $display("FAIL bp_match_after got %0d want 4", match_count); end
    tests_run++; if (mismatch_count !== 16'd1) begin tests_failed++; $display("FAIL bp_mismatch_after got %0d want 1", mismatch_count); end
  endtask

  task automatic test_saturation;
    int got, got4;
    got = 0; got4 = 0;
    do_reset();
    outs_ready = 1'b1;
    ins = K;
    for (int c = 0; c < 24; c++) begin
      ins_valid = (c < 20);
      if (outs_valid && outs_ready && outs) got++;
      if (outs_valid4 && outs_ready && outs4) got4++;
      step();
    end
    ins_valid = 1'b0;
    tests_run++; if (got != 20) begin tests_failed++; $display("FAIL sat_results_w16 got %0d want 20", got); end
    tests_run++; if (got4 != 20) begin tests_failed++; $display("FAIL sat_results_w4 got %0d want 20", got4); end
    tests_run++; if (match_count4 !== 4'd15) begin tests_failed++; $display("FAIL sat_match_count_w4 got %0d want 15", match_count4); end
    tests_run++; if (match_count !== 16'd20) begin tests_failed++; $display("FAIL sat_match_count_w16 got %0d want 20", match_count); end
    tests_run++; if (mismatch_count4 !== 4'd0 || err_sticky4 !== 1'b0 || ins_ready4 !== 1'b1) begin
      tests_failed++; $display("FAIL sat_w4_side got mis %0d err %b rdy %b want 0 0 1", mismatch_count4, err_sticky4, ins_ready4);
    end
  endtask

  task automatic test_random;
    int sent, rcv, cyc, bad, hold_bad, ref_match, ref_mis;
    logic fire_in, fire_out, prev_stall, prev_outs;
    sent = 0; rcv = 0; cyc = 0; bad = 0; hold_bad = 0; ref_match = 0; ref_mis = 0;
    prev_stall = 1'b0; prev_outs = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(9) == 0) begin
        tok_dat[i] = K ^ (37'd1 << $urandom_range(36));
        tok_exp[i] = 1'b0;
        ref_mis++;
      end else begin
        tok_dat[i] = K;
        tok_exp[i] = 1'b1;
        ref_match++;
      end
    end
    do_reset();
    while (rcv < 1000 && cyc < 20000) begin
      if (!ins_valid && sent < 1000 && $urandom_range(9) < 7) begin
        ins_valid = 1'b1;
        ins = tok_dat[sent];
      end
      outs_ready = ($urandom_range(9) < 7);
      if (prev_stall && (outs_valid !== 1'b1 || outs !== prev_outs)) hold_bad++;
      fire_in = ins_valid && ins_ready;
      fire_out = outs_valid && outs_ready;
      if (fire_out) begin
        if (outs !== tok_exp[rcv]) bad++;
        rcv++;
      end
      prev_stall = outs_valid && !outs_ready;
      prev_outs = outs;
      step();
      cyc++;
      if (fire_in) begin
        sent++;
        ins_valid = 1'b0;
      end
    end
    ins_valid = 1'b0;
    tests_run++; if (rcv != 1000) begin tests_failed++; $display("FAIL rand_received got %0d want 1000 (cycle bound)", rcv); end
    tests_run++; if (sent != 1000) begin tests_failed++; $display("FAIL rand_sent got %0d want 1000", sent); end
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL rand_order got %0d wrong results want 0", bad); end
    tests_run++; if (hold_bad != 0) begin tests_failed++; $display("FAIL rand_hold got %0d unstable stalls want 0", hold_bad); end
    tests_run++; if (match_count !== 16'(ref_match)) begin tests_failed++; $display("FAIL rand_match_count got %0d want %0d", match_count, ref_match); end
    tests_run++; if (mismatch_count !== 16'(ref_mis)) begin tests_failed++; $display("FAIL rand_mismatch_count got %0d want %0d", mismatch_count, ref_mis); end
    tests_run++; if (err_sticky !== (ref_mis > 0)) begin tests_failed++; $display("FAIL rand_err_sticky got %b want %b", err_sticky, (ref_mis > 0)); end
  endtask

  task automatic test_async_reset;
    do_reset();
    outs_ready = 1'b0;
    ins = K ^ 37'd4; ins_valid = 1'b1;
    step();
    ins = K;
    step();
    ins_valid = 1'b0;
    tests_run++; if (outs_valid !== 1'b1 || ins_ready !== 1'b0 || err_sticky !== 1'b1) begin
      tests_failed++; $display("FAIL ar_pre_state got v %b rdy %b err %b want 1 0 1", outs_valid, ins_ready, err_sticky);
    end
    #3;
    rst = 1'b0;
    #1;
    tests_run++; if (outs_valid !== 1'b0) begin tests_failed++; $display("FAIL ar_outs_valid got %b want 0", outs_valid); end
    tests_run++; if (ins_ready !== 1'b1) begin tests_failed++; $display("FAIL ar_ins_ready got %b want 1", ins_ready); end
    tests_run++; if (match_count !== 16'd0 || mismatch_count !== 16'd0) begin
      tests_failed++; $display("FAIL ar_counters got %0d %0d want 0 0", match_count, mismatch_count);
    end
    tests_run++; if (err_sticky !== 1'b0) begin tests_failed++; $display("FAIL ar_err_sticky got %b want 0", err_sticky); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    outs_ready = 1'b1;
    ins = K; ins_valid = 1'b1;
    step();
    ins_valid = 1'b0;
    tests_run++; if (outs_valid !== 1'b1 || outs !== 1'b1) begin
      tests_failed++; $display("FAIL ar_first_token got v %b o %b want 1 1", outs_valid, outs);
    end
    tests_run++; if (match_count !== 16'd1 || mismatch_count !== 16'd0 || err_sticky !== 1'b0) begin
      tests_failed++; $display("FAIL ar_first_stats got %0d %0d %b want 1 0 0", match_count, mismatch_count, err_sticky);
    end
  endtask

  initial begin
    rst = 1'b0;
    ins = '0;
    ins_valid = 1'b0;
    outs_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
